// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receiver: register map, CTRL/STATUS bit
// positions and receiver state encoding.
package spi_rx_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_FRAMES = 2'd3;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_BUSY      = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_e;

endpackage

// File: rtl/spi_rx_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; pointers carry an extra wrap
// bit so full and empty are distinguishable.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    assign dout  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 target receiver: synchronizes the SPI pins, assembles MSB-first
// bytes into a FIFO and exposes CTRL/STATUS/DATA/FRAMES on the slave bus.
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        irq
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0] cs_pipe_q, cs_pipe_d;
    logic [2:0] sclk_pipe_q, sclk_pipe_d;
    logic [2:0] mosi_pipe_q, mosi_pipe_d;

    rx_state_e state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       push_q, push_d;
    logic [7:0] push_data_q, push_data_d;

    logic                   en_q, en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   overrun_q, overrun_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;
    logic                   ready_q, ready_d;
    logic [31:0]            data_o_q, data_o_d;

    logic             cs_s, mosi_s, cs_fall, cs_rise, sclk_rise;
    logic             access, wr, rd, pop, flush;
    logic [1:0]       reg_sel;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full, fifo_empty;
    logic [31:0]      status;
    logic             unused_ok;

    assign unused_ok = ^{addr[1:0], data_i[31:3]};

    assign cs_pipe_d   = {cs_pipe_q[1:0], spi_cs};
    assign sclk_pipe_d = {sclk_pipe_q[1:0], spi_clk};
    assign mosi_pipe_d = {mosi_pipe_q[1:0], spi_mosi};

    assign cs_s      = cs_pipe_q[1];
    assign mosi_s    = mosi_pipe_q[1];
    assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];
    assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
    assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];

    assign reg_sel = addr[3:2];
    assign access  = select & ~ready_q;
    assign wr      = access & (|wstrb);
    assign rd      = access & ~(|wstrb);
    assign pop     = rd && (reg_sel == REG_DATA);
    assign flush   = wr && (reg_sel == REG_CTRL) && wstrb[0] && data_i[CTRL_FLUSH];

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        case (state_q)
            RX_IDLE: begin
                bitcnt_d = '0;
                if (cs_fall && en_q) state_d = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (cs_rise || !en_q) begin
                    state_d  = RX_IDLE;
                    bitcnt_d = '0;
                end else if (sclk_rise && !cs_s) begin
                    sr_d     = {sr_q[6:0], mosi_s};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        push_d      = 1'b1;
                        push_data_d = {sr_q[6:0], mosi_s};
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        status                          = '0;
        status[ST_NOT_EMPTY]            = ~fifo_empty;
        status[ST_FULL]                 = fifo_full;
        status[ST_OVERRUN]              = overrun_q;
        status[ST_BUSY]                 = ~cs_s;
        status[ST_LEVEL_LSB +: 8]       = 8'(fifo_level);
    end

    always_comb begin
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        overrun_d = overrun_q;
        frames_d  = frames_q;
        ready_d   = access;
        data_o_d  = '0;

        if (wr && reg_sel == REG_CTRL && wstrb[0]) begin
            en_d     = data_i[CTRL_EN];
            irq_en_d = data_i[CTRL_IRQ_EN];
        end
        if (wr && reg_sel == REG_STATUS && wstrb[0] && data_i[ST_OVERRUN]) overrun_d = 1'b0;
        // The FIFO itself decides acceptance; a full FIFO with no pop drops the byte.
        if (push_q && fifo_full && !pop) overrun_d = 1'b1;

        if (wr && reg_sel == REG_FRAMES)  frames_d = '0;
        else if (cs_rise && en_q)         frames_d = frames_q + 1'b1;

        if (rd) begin
            case (reg_sel)
                REG_CTRL:   data_o_d = {30'd0, irq_en_q, en_q};
                REG_STATUS: data_o_d = status;
                REG_DATA:   data_o_d = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                default:    data_o_d = 32'(frames_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_pipe_q   <= '1;
            sclk_pipe_q <= '0;
            mosi_pipe_q <= '0;
            state_q     <= RX_IDLE;
            sr_q        <= '0;
            bitcnt_q    <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frames_q    <= '0;
            ready_q     <= 1'b0;
            data_o_q    <= '0;
        end else begin
            cs_pipe_q   <= cs_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            overrun_q   <= overrun_d;
            frames_q    <= frames_d;
            ready_q     <= ready_d;
            data_o_q    <= data_o_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_q),
        .pop   (pop),
        .flush (flush),
        .din   (push_data_q),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready  = ready_q;
    assign data_o = data_o_q;
    assign irq    = irq_en_q & ~fifo_empty;

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: a queue-based receiver model predicts every bus
// read; a monitor compares each read response as ready is presented.
module tb_spi_rx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [3:0]  addr = '0;
    logic [31:0] data_i = '0;
    logic        ready;
    logic [31:0] data_o;
    logic        spi_cs = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        irq;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model state
    logic [7:0]  mq[$];
    logic        m_en = 1'b0, m_irqen = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_frames = '0;

    // scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        is_read = 1'b0;

    spi_rx #(.FIFO_DEPTH(DEPTH), .FRAME_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .ready(ready), .data_o(data_o), .spi_cs(spi_cs),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() != 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_ovr;
        s[3] = ~spi_cs;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'd0;
        return {24'd0, mq.pop_front()};
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_en = 0; m_irqen = 0; m_ovr = 0; m_frames = '0;
    endfunction

    task automatic bus_core(input logic [3:0] a, input logic [3:0] ws, input logic [31:0] d);
        int n;
        addr = a; wstrb = ws; data_i = d; is_read = (ws == 4'd0); select = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 20);
        if (!ready) begin
            vectors++; miscompares++;
            $display("FAIL bus_timeout: got no ready expected ready within 20 cycles");
            if (is_read && exp_q.size() != 0) begin
                void'(exp_q.pop_front()); void'(name_q.pop_front());
            end
        end
        select = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_core(a, 4'hF, d);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus_core(a, 4'h0, 32'd0);
    endtask

    task automatic write_ctrl(input logic [2:0] v);
        m_en = v[0]; m_irqen = v[1];
        if (v[2]) mq.delete();
        bus_write(4'h0, {29'd0, v});
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        cycles(4);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        if (m_en) m_frames++;
        cycles(8);
    endtask

    // mode 0: plain, 1: measure irq latency on bit 7, 2: DATA pop timed onto the push
    task automatic send_bits(input logic [7:0] b, input int nbits, input int mode, input bit counts);
        int k;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            cycles(4);
            spi_clk = 1'b1;
            if (i == 7 && mode == 1) begin
                k = 0;
                do begin @(negedge clk); k++; end while (!irq && k < 8);
                chk("irq_latency", 32'(k), 32'd4);
                cycles(4);
            end else if (i == 7 && mode == 2) begin
                cycles(3);
                exp_q.push_back(m_pop());
                name_q.push_back("collide_pop");
                bus_core(4'h8, 4'h0, 32'd0);
                cycles(3);
            end else begin
                cycles(4);
            end
            spi_clk = 1'b0;
        end
        cycles(4);
        if (nbits == 8 && counts) m_push(b);
    endtask

    // monitor: one expected entry per read acknowledge
    initial begin
        forever begin
            @(negedge clk);
            if (ready && is_read) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_read: got 0x%08h expected no response", data_o);
                end else begin
                    chk(name_q.pop_front(), data_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        int nb, op;

        // reset state
        cycles(3);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        cycles(3);
        bus_read(4'h0, 32'd0, "rst_ctrl");
        bus_read(4'h4, m_status(), "rst_status");
        bus_read(4'hC, 32'd0, "rst_frames");

        // basic receive
        write_ctrl(3'b001);
        cs_low();
        send_bits(8'hA5, 8, 0, 1);
        send_bits(8'h3C, 8, 0, 1);
        cs_high();
        bus_read(4'h4, m_status(), "basic_status");
        chk("basic_irq_off", {31'd0, irq}, 32'd0);
        bus_read(4'h8, m_pop(), "basic_data0");
        bus_read(4'h8, m_pop(), "basic_data1");
        bus_read(4'hC, 32'(m_frames), "basic_frames");

        // interrupt latency and empty read
        write_ctrl(3'b011);
        bus_read(4'h0, 32'd3, "ctrl_readback");
        r = 8'($urandom);
        cs_low();
        send_bits(r, 8, 1, 1);
        cs_high();
        bus_read(4'h8, m_pop(), "irq_data");
        chk("irq_after_pop", {31'd0, irq}, 32'd0);
        bus_read(4'h8, m_pop(), "empty_read");
        bus_read(4'h4, m_status(), "empty_status");

        // partial byte then a full frame
        write_ctrl(3'b001);
        m_frames = '0;
        bus_write(4'hC, 32'hFFFF_FFFF);
        cs_low();
        send_bits(8'hF8, 5, 0, 0);
        cs_high();
        cs_low();
        send_bits(8'h81, 8, 0, 1);
        cs_high();
        bus_read(4'h4, m_status(), "partial_status");
        bus_read(4'h8, m_pop(), "partial_data");
        bus_read(4'hC, 32'(m_frames), "partial_frames");

        // overrun, collision, flush
        cs_low();
        for (int i = 0; i < 9; i++) send_bits(8'(i), 8, 0, 1);
        cs_high();
        bus_read(4'h4, m_status(), "ovr_status");
        bus_read(4'h8, m_pop(), "ovr_head");
        m_ovr = 1'b0;
        bus_write(4'h4, 32'h4);
        bus_read(4'h4, m_status(), "ovr_cleared");
        cs_low();
        send_bits(8'h55, 8, 0, 1);
        send_bits(8'h66, 8, 2, 1);
        bus_read(4'h4, m_status(), "collide_status");
        send_bits(8'h77, 8, 0, 1);
        cs_high();
        bus_read(4'h4, m_status(), "ovr_again");
        write_ctrl(3'b101);
        bus_read(4'h0, 32'd1, "flush_ctrl");
        bus_read(4'h4, m_status(), "flush_status");
        bus_read(4'hC, 32'(m_frames), "flush_frames");
        bus_write(4'h4, 32'h4);
        m_ovr = 1'b0;

        // reset during bit 4 of a frame
        cs_low();
        send_bits(8'hC3, 4, 0, 0);
        reset = 1'b1;
        m_reset();
        cycles(2);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        cycles(2);
        write_ctrl(3'b001);
        send_bits(8'h3C, 4, 0, 0);
        send_bits(8'h5A, 8, 0, 0);
        cs_high();
        bus_read(4'h4, m_status(), "midrst_status");
        bus_read(4'hC, 32'(m_frames), "midrst_frames");

        // disable mid-byte keeps earlier data
        r = 8'($urandom);
        cs_low();
        send_bits(r, 8, 0, 1);
        send_bits(8'hE7, 3, 0, 0);
        write_ctrl(3'b000);
        send_bits(8'h1F, 5, 0, 0);
        cs_high();
        bus_read(4'h4, m_status(), "dis_status");
        bus_read(4'h8, m_pop(), "dis_data");

        // randomized frames and reads
        write_ctrl({2'b00, 1'($urandom)} | 3'b001);
        write_ctrl({1'b0, 1'($urandom), 1'b1});
        for (int f = 0; f < 16; f++) begin
            nb = $urandom_range(1, 3);
            cs_low();
            for (int j = 0; j < nb; j++) send_bits(8'($urandom), 8, 0, 1);
            cs_high();
            chk("rand_irq", {31'd0, irq}, {31'd0, m_irqen && mq.size() != 0});
            for (int j = 0; j < 2; j++) begin
                op = $urandom_range(0, 3);
                case (op)
                    0: bus_read(4'h8, m_pop(), "rand_data");
                    1: bus_read(4'h4, m_status(), "rand_status");
                    2: bus_read(4'hC, 32'(m_frames), "rand_frames");
                    default: cycles(2);
                endcase
            end
        end
        while (mq.size() != 0) bus_read(4'h8, m_pop(), "drain_data");
        bus_read(4'h4, m_status(), "drain_status");

        cycles(4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish expected finish before 5ms");
        $fatal(1);
    end

endmodule
